// File: rtl/sdu_dbg_ctrl.sv
// Serial debug controller: byte-stream command decoder that halts, runs and
// single-steps the CPU through a clock-enable, holds PC breakpoints, and
// performs debug bus reads/writes while the CPU is halted.
//
// Handshakes: a byte moves on rx (or tx) only in a cycle where valid and
// ready are both high. A producer holding valid keeps its data stable until
// that cycle, and ready never depends on valid.
module sdu_dbg_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BP     = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_pc,
    output logic                  cpu_en,
    output logic                  dbg_req,
    output logic                  dbg_we,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic [DATA_WIDTH-1:0] dbg_rdata,
    input  logic                  dbg_ack,
    output logic                  halted
);
    localparam logic [7:0] AB_B     = 8'(ADDR_WIDTH / 8);
    localparam logic [7:0] DB_B     = 8'(DATA_WIDTH / 8);
    localparam logic [7:0] NUM_BP_B = 8'(NUM_BP);

    localparam logic [7:0] OP_H = 8'h48, OP_R = 8'h52, OP_S = 8'h53, OP_B = 8'h42;
    localparam logic [7:0] OP_C = 8'h43, OP_M = 8'h4D, OP_W = 8'h57, OP_Q = 8'h51;
    localparam logic [7:0] RSP_K = 8'h4B, RSP_ERR = 8'h3F, RSP_RUN = 8'h21;

    typedef enum logic [2:0] {ST_IDLE, ST_ARGS, ST_BUS, ST_STEP, ST_RESP} state_e;

    state_e                state_q, state_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic [7:0]            resp_cnt_q, resp_cnt_d;
    logic                  halted_q, halted_d;
    logic                  skip_q, skip_d;
    logic [3:0]            hit_q, hit_d;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] bp_addr_q [NUM_BP];
    logic [ADDR_WIDTH-1:0] bp_addr_d [NUM_BP];
    logic [NUM_BP-1:0]     bp_en_q, bp_en_d;

    logic [NUM_BP-1:0] bp_hit_vec;
    logic [3:0]        hit_lowest;
    logic              bp_match_eff;
    logic              step_pulse;
    logic              rx_fire, tx_fire;
    logic              skip_set;

    // Response bytes sit MSB-first in resp_q; a single byte goes in the top lane.
    function automatic logic [DATA_WIDTH-1:0] one_byte(input logic [7:0] b);
        return DATA_WIDTH'(b) << (DATA_WIDTH - 8);
    endfunction

    // Breakpoint comparators and lowest-index priority pick.
    always_comb begin
        hit_lowest = 4'd0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_hit_vec[i] = bp_en_q[i] && (bp_addr_q[i] == cpu_pc);
        end
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_hit_vec[i]) hit_lowest = 4'(i);
        end
    end

    assign bp_match_eff = (|bp_hit_vec) & ~skip_q;
    assign step_pulse   = (state_q == ST_STEP);
    assign cpu_en       = (~halted_q & ~bp_match_eff) | step_pulse;

    assign rx_ready  = ready_q && (state_q == ST_IDLE || state_q == ST_ARGS);
    assign rx_fire   = rx_valid & rx_ready;
    assign tx_valid  = (state_q == ST_RESP);
    assign tx_data   = resp_q[DATA_WIDTH-1 -: 8];
    assign tx_fire   = tx_valid & tx_ready;
    assign dbg_req   = (state_q == ST_BUS);
    assign dbg_we    = dbg_req && (opcode_q == OP_W);
    assign dbg_addr  = addr_q;
    assign dbg_wdata = wdata_q;
    assign halted    = halted_q;

    // Command FSM next state, argument shifting and execution control.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        halted_d   = halted_q;
        skip_d     = skip_q;
        hit_d      = hit_q;
        bp_addr_d  = bp_addr_q;
        bp_en_d    = bp_en_q;
        skip_set   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    opcode_d   = rx_data;
                    resp_cnt_d = 8'd1;
                    state_d    = ST_RESP;
                    case (rx_data)
                        OP_H: begin halted_d = 1'b1; resp_d = one_byte(RSP_K); end
                        OP_R: begin halted_d = 1'b0; skip_set = 1'b1; resp_d = one_byte(RSP_K); end
                        OP_S: state_d = ST_STEP;
                        OP_B: begin cnt_d = AB_B + 8'd1; state_d = ST_ARGS; end
                        OP_C: begin cnt_d = 8'd1;        state_d = ST_ARGS; end
                        OP_M: begin cnt_d = AB_B;        state_d = ST_ARGS; end
                        OP_W: begin cnt_d = AB_B + DB_B; state_d = ST_ARGS; end
                        OP_Q: resp_d = one_byte({halted_q, 3'b000, hit_q});
                        default: resp_d = one_byte(RSP_ERR);
                    endcase
                end
            end
            ST_ARGS: begin
                if (rx_fire) begin
                    cnt_d = cnt_q - 8'd1;
                    if ((opcode_q == OP_B && cnt_q == AB_B + 8'd1) || opcode_q == OP_C) begin
                        idx_d = rx_data;
                    end else if (opcode_q == OP_W && cnt_q <= DB_B) begin
                        wdata_d = (wdata_q << 8) | DATA_WIDTH'(rx_data);
                    end else begin
                        addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data);
                    end
                    // Last argument byte: execute the command.
                    if (cnt_q == 8'd1) begin
                        resp_cnt_d = 8'd1;
                        state_d    = ST_RESP;
                        case (opcode_q)
                            OP_B: begin
                                for (int i = 0; i < NUM_BP; i++) begin
                                    if (idx_q == 8'(i)) begin
                                        bp_addr_d[i] = addr_d;
                                        bp_en_d[i]   = 1'b1;
                                    end
                                end
                                resp_d = one_byte((idx_q < NUM_BP_B) ? RSP_K : RSP_ERR);
                            end
                            OP_C: begin
                                for (int i = 0; i < NUM_BP; i++) begin
                                    if (rx_data == 8'(i)) bp_en_d[i] = 1'b0;
                                end
                                resp_d = one_byte((rx_data < NUM_BP_B) ? RSP_K : RSP_ERR);
                            end
                            default: begin
                                // 'M' and 'W' touch the bus only while halted.
                                if (halted_q) state_d = ST_BUS;
                                else          resp_d  = one_byte(RSP_RUN);
                            end
                        endcase
                    end
                end
            end
            ST_BUS: begin
                if (dbg_ack) begin
                    state_d = ST_RESP;
                    if (opcode_q == OP_W) begin
                        resp_d     = one_byte(RSP_K);
                        resp_cnt_d = 8'd1;
                    end else begin
                        resp_d     = dbg_rdata;
                        resp_cnt_d = DB_B;
                    end
                end
            end
            ST_STEP: begin
                resp_d     = one_byte(RSP_K);
                resp_cnt_d = 8'd1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (tx_fire) begin
                    resp_d     = resp_q << 8;
                    resp_cnt_d = resp_cnt_q - 8'd1;
                    if (resp_cnt_q == 8'd1) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // skip_once lasts until the first enabled cycle; a new 'R' re-arms it.
        if (cpu_en)   skip_d = 1'b0;
        if (skip_set) skip_d = 1'b1;

        // A breakpoint hit while running halts before the instruction executes.
        if (~halted_q & bp_match_eff) begin
            halted_d = 1'b1;
            hit_d    = hit_lowest;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            state_q    <= ST_IDLE;
            opcode_q   <= 8'd0;
            cnt_q      <= 8'd0;
            idx_q      <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            resp_cnt_q <= 8'd0;
            halted_q   <= 1'b1;
            skip_q     <= 1'b0;
            hit_q      <= 4'd0;
            ready_q    <= 1'b0;
            bp_en_q    <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
            halted_q   <= halted_d;
            skip_q     <= skip_d;
            hit_q      <= hit_d;
            ready_q    <= 1'b1;
            bp_en_q    <= bp_en_d;
            for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= bp_addr_d[i];
        end
    end

endmodule

// File: tb/tb_sdu_dbg_ctrl.sv
// Bench for sdu_dbg_ctrl: directed command sequences, a tx scoreboard fed
// from stimulus and drained by a monitor, and a req/ack bus memory model.
module tb_sdu_dbg_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          cpu_rstn;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready;
    logic [AW-1:0] cpu_pc;
    logic          cpu_en;
    logic          dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          halted;

    sdu_dbg_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BP(NB)) dut (
        .cpu_clk(clk), .cpu_rstn(cpu_rstn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cpu_pc(cpu_pc), .cpu_en(cpu_en),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .halted(halted)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // ---------------- tx monitor ----------------
    logic       held = 1'b0;
    logic [7:0] held_data;
    int         en_cycles = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cpu_en) en_cycles++;
            if (!cpu_rstn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("tx_hold_valid", tx_valid, 1);
                    if (tx_valid) check("tx_hold_data", tx_data, held_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL tx_unexpected: actual=0x%0h required=no byte", tx_data);
                    end else begin
                        check("tx_byte", tx_data, exp_q.pop_front());
                    end
                end
                held      = tx_valid && !tx_ready;
                held_data = tx_data;
            end
        end
    end

    // ---------------- bus memory model ----------------
    logic          ack_en = 1'b1;
    int            ack_delay = 1;
    int            req_cnt = 0;
    int            last_req_cycles = 0;
    int            total_req = 0;
    logic [DW-1:0] mem = '0;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    initial begin
        dbg_ack   = 1'b0;
        dbg_rdata = '0;
        forever begin
            @(negedge clk);
            if (dbg_ack) begin
                dbg_ack = 1'b0;
            end else if (dbg_req) begin
                req_cnt++;
                total_req++;
                if (ack_en && req_cnt >= ack_delay) begin
                    check("bus_we", dbg_we, exp_we);
                    check("bus_addr", dbg_addr, exp_addr);
                    if (exp_we) check("bus_wdata", dbg_wdata, exp_wdata);
                    if (dbg_we) mem = dbg_wdata;
                    dbg_rdata       = mem;
                    dbg_ack         = 1'b1;
                    last_req_cycles = req_cnt;
                    req_cnt         = 0;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("rx_accept_timeout", t, 0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || !rx_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drain_timeout"}, t >= 300, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0, r0, t;
        cpu_rstn = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        cpu_pc   = '0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_halted",   halted, 1);
        check("rst_cpu_en",   cpu_en, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_dbg_req",  dbg_req, 0);
        check("rst_dbg_we",   dbg_we, 0);
        check("rst_dbg_addr", dbg_addr, 0);
        check("rst_dbg_wdata", dbg_wdata, 0);
        cpu_rstn = 1'b1;
        @(negedge clk);
        check("rx_ready_after_reset", rx_ready, 1);

        // 1: status after reset
        exp_q.push_back(8'h80);
        send_byte(8'h51);
        drain("q_reset");
        check("cpu_en_never_high", en_cycles, 0);

        // 2: breakpoint at 0x10, run into it, resume past it
        exp_q.push_back(8'h4B);
        send_byte(8'h42); send_byte(8'h00); send_word(32'h0000_0010);
        drain("bp_set");
        cpu_pc = 32'h08;
        exp_q.push_back(8'h4B);
        send_byte(8'h52);
        #1 check("run_en_pc08", cpu_en, 1);
        @(negedge clk); cpu_pc = 32'h0C;
        #1 check("run_en_pc0c", cpu_en, 1);
        check("run_halted_pc0c", halted, 0);
        @(negedge clk); cpu_pc = 32'h10;
        #1 check("bp_en_drop", cpu_en, 0);
        check("bp_not_yet_halted", halted, 0);
        @(negedge clk);
        #1 check("bp_halted", halted, 1);
        drain("run1");
        exp_q.push_back(8'h80);
        send_byte(8'h51);
        drain("q_hit0");
        exp_q.push_back(8'h4B);
        send_byte(8'h52);
        #1 check("resume_en_at_bp", cpu_en, 1);
        @(negedge clk); cpu_pc = 32'h14;
        #1 check("resume_en_pc14", cpu_en, 1);
        check("resume_running", halted, 0);
        @(negedge clk); cpu_pc = 32'h10;
        #1 check("bp_again_en", cpu_en, 0);
        @(negedge clk);
        #1 check("bp_again_halted", halted, 1);
        drain("run2");

        // 3: single step, including from a breakpoint address
        for (int k = 0; k < 2; k++) begin
            cpu_pc = (k == 0) ? 32'h10 : 32'h20;
            e0 = en_cycles;
            exp_q.push_back(8'h4B);
            send_byte(8'h53);
            #1 check("step_en_high", cpu_en, 1);
            @(negedge clk);
            #1 check("step_en_low", cpu_en, 0);
            drain("step");
            check("step_en_cycles", en_cycles - e0, 1);
            check("step_still_halted", halted, 1);
        end

        // 4: bus write with delayed ack, then read back with tx back-pressure
        exp_we = 1'b1; exp_addr = 32'h40; exp_wdata = 32'hDEAD_BEEF;
        ack_delay = 3;
        exp_q.push_back(8'h4B);
        send_byte(8'h57); send_word(32'h0000_0040); send_word(32'hDEAD_BEEF);
        drain("write");
        check("write_req_cycles", last_req_cycles, 3);
        ack_delay = 1;
        exp_we = 1'b0;
        tx_ready = 1'b0;
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        send_byte(8'h4D); send_word(32'h0000_0040);
        t = 0;
        while (!tx_valid && t < 50) begin @(negedge clk); t++; end
        check("read_resp_timeout", t >= 50, 0);
        repeat (2) @(negedge clk);
        tx_ready = 1'b1;
        drain("read");

        // 5: error responses while running, hit index reporting
        cpu_pc = 32'h30;
        exp_q.push_back(8'h4B);
        send_byte(8'h52);
        drain("run3");
        check("running", halted, 0);
        r0 = total_req;
        exp_q.push_back(8'h21);
        send_byte(8'h4D); send_word(32'h0000_0040);
        drain("m_running");
        exp_q.push_back(8'h21);
        send_byte(8'h57); send_word(32'h0000_0040); send_word(32'h1111_1111);
        drain("w_running");
        check("no_bus_while_running", total_req - r0, 0);
        exp_q.push_back(8'h3F);
        send_byte(8'h42); send_byte(8'h07); send_word(32'h0000_0030);
        drain("bp_bad_idx");
        check("bad_idx_no_hit", cpu_en, 1);
        exp_q.push_back(8'h3F);
        send_byte(8'h43); send_byte(8'h09);
        drain("clr_bad_idx");
        exp_q.push_back(8'h3F);
        send_byte(8'h5A);
        drain("bad_op");
        exp_q.push_back(8'h00);
        send_byte(8'h51);
        drain("q_running");
        exp_q.push_back(8'h4B);
        send_byte(8'h42); send_byte(8'h02); send_word(32'h0000_0050);
        drain("bp2_set");
        exp_q.push_back(8'h4B);
        send_byte(8'h43); send_byte(8'h00);
        drain("bp0_clr");
        cpu_pc = 32'h10;
        #1 check("bp0_cleared_en", cpu_en, 1);
        @(negedge clk); cpu_pc = 32'h50;
        #1 check("bp2_en_drop", cpu_en, 0);
        @(negedge clk);
        #1 check("bp2_halted", halted, 1);
        exp_q.push_back(8'h82);
        send_byte(8'h51);
        drain("q_hit2");
        exp_q.push_back(8'h4B);
        send_byte(8'h48);
        drain("halt");
        check("halt_cmd", halted, 1);

        // 6: reset while a bus request is outstanding
        ack_en = 1'b0;
        send_byte(8'h57); send_word(32'h0000_0044); send_word(32'h0102_0304);
        t = 0;
        while (!dbg_req && t < 20) begin @(negedge clk); t++; end
        check("bus_req_seen", dbg_req, 1);
        @(negedge clk);
        cpu_rstn = 1'b0;
        @(negedge clk);
        check("abort_dbg_req", dbg_req, 0);
        check("abort_halted", halted, 1);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_rx_ready", rx_ready, 0);
        cpu_rstn = 1'b1;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h80);
        send_byte(8'h51);
        drain("q_after_abort");
        cpu_pc = 32'h10;
        exp_q.push_back(8'h4B);
        send_byte(8'h52);
        drain("run_after_abort");
        check("bp0_gone_en", cpu_en, 1);
        check("bp0_gone_running", halted, 0);
        @(negedge clk); cpu_pc = 32'h50;
        #1 check("bp2_gone_en", cpu_en, 1);
        @(negedge clk);
        #1 check("bp2_gone_running", halted, 0);

        drain("end");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdu_dbg_ctrl.md
Name: sdu_dbg_ctrl

Overview:
- Parametrised serial debug controller that sits between a byte-stream UART link and the CPU core, generalising the bare SDU wrapper.
- Gates CPU execution through a clock-enable and supports halt, run and single-step.
- Holds NUM_BP hardware PC breakpoints.
- Performs debug memory reads and writes over a simple req/ack bus while the CPU is halted.

Parameters:
ADDR_WIDTH, 32, PC/bus address width; multiple of 8; AB=ADDR_WIDTH/8 address bytes.
DATA_WIDTH, 32, bus data width; multiple of 8; DB=DATA_WIDTH/8 data bytes.
NUM_BP, 4, number of breakpoint comparators; range 1..16.

Ports:
cpu_clk  in  1  system clock.
cpu_rstn  in  1  reset; synchronous, active-low.
rx_data  in  8  command byte.
rx_valid  in  1  command byte valid.
rx_ready  out  1  controller accepts the byte when rx_valid&rx_ready.
tx_data  out  8  response byte.
tx_valid  out  1  response byte valid.
tx_ready  in  1  downstream accepts the byte when tx_valid&tx_ready.
cpu_pc  in  ADDR_WIDTH  PC of the instruction the CPU executes when next enabled.
cpu_en  out  1  CPU clock-enable.
dbg_req  out  1  bus request.
dbg_we  out  1  1=write, 0=read.
dbg_addr  out  ADDR_WIDTH  bus address.
dbg_wdata  out  DATA_WIDTH  bus write data.
dbg_rdata  in  DATA_WIDTH  bus read data; valid with dbg_ack.
dbg_ack  in  1  one-cycle completion pulse.
halted  out  1  CPU halted status.

Behaviour:
- Reset (cpu_rstn=0 at a cpu_clk edge), all outputs:
  - halted=1, cpu_en=0.
  - All breakpoints disabled; hit index cleared to 0.
  - FSM in IDLE.
  - rx_ready=0 the cycle after reset, then 1 in IDLE.
  - tx_valid=0, dbg_req=0, dbg_we=0, dbg_addr=0, dbg_wdata=0.
- Reset mid-operation aborts any command, including an outstanding bus request; no response byte is emitted.
- Multi-byte arguments and responses are sent MSB byte first.
- Commands (first byte, ASCII):
  - 'H' (0x48): halted<=1; respond 'K'.
  - 'R' (0x52): halted<=0; skip_once<=1; respond 'K'.
  - 'S' (0x53): step one instruction; respond 'K' after the step cycle.
  - 'B' (0x42): args idx(1 byte) + AB addr bytes; bp[idx]<=addr, enabled; respond 'K'.
  - 'C' (0x43): arg idx(1 byte); disable bp[idx]; respond 'K'.
  - 'M' (0x4D): AB addr bytes; bus read; respond with DB data bytes.
  - 'W' (0x57): AB addr bytes + DB data bytes; bus write; respond 'K'.
  - 'Q' (0x51): respond with one status byte {halted, 3'b0, hit_idx[3:0]}.
  - Any other byte: respond '?' (0x3F).
- Error responses:
  - idx >= NUM_BP: all args are consumed, no register changes, respond '?'.
  - 'M' or 'W' while halted=0: all args are consumed, no bus access, respond '!' (0x21).
- FSM states:
  - IDLE: rx_ready=1; decode the opcode byte.
  - ARGS: rx_ready=1; shift in the expected argument count.
  - BUS: dbg_req=1 with addr/we/wdata held stable until the dbg_ack cycle. For reads, dbg_rdata is captured on that same cycle. dbg_req drops the cycle after ack.
  - STEP: cpu_en=1 for exactly one cycle.
  - RESP: tx_valid=1, tx_data stable until tx_ready, one byte per handshake; returns to IDLE after the last byte.
  - rx_ready=0 in BUS, STEP and RESP; commands are strictly serialised.
- Execution gating: cpu_en = (~halted & ~bp_match_eff) | step_pulse, where bp_match_eff = any enabled bp[i]==cpu_pc & ~skip_once.
- Breakpoint hit:
  - On a cycle with ~halted & bp_match_eff, cpu_en=0 combinationally, so the breakpoint instruction is not executed.
  - halted<=1; hit_idx<=lowest matching index.
- skip_once clears after the first cycle with cpu_en=1, so resuming from a breakpoint executes that instruction.
- Step ignores breakpoints.
- Simultaneous events: a hit cycle and an 'H' decode both set halted; no conflict.
- 'R' while already running: respond 'K', state unchanged except skip_once<=1.
- Latency: 'H'/'R'/'C' have tx_valid in the cycle after the last byte is accepted. 'B' has the same latency.

Test Plan:
1. Reset, send 'Q' -> tx 0x80; cpu_en=0 throughout.
2. 'B' 00 00 00 00 10, then 'R'; drive cpu_pc 0x08,0x0C,0x10 -> cpu_en drops combinationally at pc 0x10, halted=1. 'Q' returns 0x80. Second 'R' -> cpu_en=1 at pc 0x10 for one cycle; the next 0x10 occurrence halts again.
3. Halted, 'S' -> cpu_en high exactly 1 cycle, then 'K', halted stays 1; also from pc=0x10 with bp at 0x10.
4. 'W' 00 00 00 40 DE AD BE EF with ack delayed 3 cycles -> dbg_req held 3 cycles, dbg_we=1, addr 0x40, wdata 0xDEADBEEF, 'K'. 'M' 00 00 00 40 with model returning 0xDEADBEEF -> tx DE AD BE EF; tx_ready held low 2 cycles keeps byte stable.
5. Running, 'M' + 4 bytes -> '!' and no dbg_req. 'B' 07 + 4 bytes with NUM_BP=4 -> '?'. Opcode 0x5A -> '?'.
6. Assert cpu_rstn=0 during BUS wait -> dbg_req=0 and halted=1 after the edge, no tx byte; breakpoint from scenario 2 is cleared.
